// File: rtl/control_unit_pkg.sv
// Shared definitions for the hardwired control sequencer: T-state encoding, opcode values
// and the datapath strobe bundle.
package cpu_defs;

  localparam int unsigned OpW = 5;

  typedef enum logic [3:0] {
    StReset,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StT7,
    StHalt
  } state_t;

  localparam logic [OpW-1:0] OpLd   = 5'b00000;
  localparam logic [OpW-1:0] OpLdi  = 5'b00001;
  localparam logic [OpW-1:0] OpSt   = 5'b00010;
  localparam logic [OpW-1:0] OpAdd  = 5'b00011;
  localparam logic [OpW-1:0] OpSub  = 5'b00100;
  localparam logic [OpW-1:0] OpAnd  = 5'b00101;
  localparam logic [OpW-1:0] OpOr   = 5'b00110;
  localparam logic [OpW-1:0] OpAddi = 5'b01100;
  localparam logic [OpW-1:0] OpNop  = 5'b11010;
  localparam logic [OpW-1:0] OpHalt = 5'b11011;

  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic md_mux_read;
    logic ram_read;
    logic ram_write;
    logic ir_in;
    logic y_in;
    logic zlow_in;
    logic zlow_out;
    logic cse_out;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic alu_add;
    logic alu_sub;
    logic alu_and;
    logic alu_or;
  } strobes_t;

  // Last T-step of each opcode; nop and unrecognised opcodes end at T2.
  function automatic state_t last_step(input logic [OpW-1:0] op);
    state_t s;
    case (op)
      OpLd, OpSt:                                  s = StT7;
      OpLdi, OpAdd, OpSub, OpAnd, OpOr, OpAddi:    s = StT5;
      default:                                     s = StT2;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: master drives strobes and run, slave supplies IR and stop.
interface control_unit_if;
  logic        stop;
  logic [31:0] IR;
  logic        run;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, RAMwrite, IRin;
  logic Yin, Zlowin, Zlowout, CSEout, Gra, Grb, Grc, Rin, Rout, BAout;
  logic ADD, SUB, AND, OR;

  modport master (
    input  stop, IR,
    output run, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, RAMwrite, IRin,
           Yin, Zlowin, Zlowout, CSEout, Gra, Grb, Grc, Rin, Rout, BAout, ADD, SUB, AND, OR
  );

  modport slave (
    output stop, IR,
    input  run, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, RAMwrite, IRin,
           Yin, Zlowin, Zlowout, CSEout, Gra, Grb, Grc, Rin, Rout, BAout, ADD, SUB, AND, OR
  );
endinterface

// File: rtl/control_unit_decode.sv
// Combinational T-state + opcode to datapath strobe decode; fetch steps ignore the opcode.
module ctrl_decode
  import cpu_defs::*;
(
  input  state_t         state_i,
  input  logic [OpW-1:0] op_i,
  output strobes_t       strobes_o
);

  logic is_mem;
  logic is_alu;

  always_comb begin
    strobes_o = '0;
    // ld/ldi/st form an effective address from the base register plus the constant.
    is_mem = (op_i == OpLd) || (op_i == OpLdi) || (op_i == OpSt);
    is_alu = (op_i == OpAdd) || (op_i == OpSub) || (op_i == OpAnd) || (op_i == OpOr);

    unique case (state_i)
      StT0: begin
        strobes_o.pc_out  = 1'b1;
        strobes_o.mar_in  = 1'b1;
        strobes_o.inc_pc  = 1'b1;
        strobes_o.zlow_in = 1'b1;
      end
      StT1: begin
        strobes_o.zlow_out    = 1'b1;
        strobes_o.pc_in       = 1'b1;
        strobes_o.md_mux_read = 1'b1;
        strobes_o.ram_read    = 1'b1;
        strobes_o.mdr_in      = 1'b1;
      end
      StT2: begin
        strobes_o.mdr_out = 1'b1;
        strobes_o.ir_in   = 1'b1;
      end
      StT3: begin
        if (is_mem) begin
          strobes_o.grb    = 1'b1;
          strobes_o.ba_out = 1'b1;
          strobes_o.y_in   = 1'b1;
        end else if (is_alu || (op_i == OpAddi)) begin
          strobes_o.grb   = 1'b1;
          strobes_o.r_out = 1'b1;
          strobes_o.y_in  = 1'b1;
        end
      end
      StT4: begin
        if (is_mem || (op_i == OpAddi)) begin
          strobes_o.cse_out = 1'b1;
          strobes_o.alu_add = 1'b1;
          strobes_o.zlow_in = 1'b1;
        end else if (is_alu) begin
          strobes_o.grc     = 1'b1;
          strobes_o.r_out   = 1'b1;
          strobes_o.zlow_in = 1'b1;
          strobes_o.alu_add = (op_i == OpAdd);
          strobes_o.alu_sub = (op_i == OpSub);
          strobes_o.alu_and = (op_i == OpAnd);
          strobes_o.alu_or  = (op_i == OpOr);
        end
      end
      StT5: begin
        if ((op_i == OpLd) || (op_i == OpSt)) begin
          strobes_o.zlow_out = 1'b1;
          strobes_o.mar_in   = 1'b1;
        end else if ((op_i == OpLdi) || is_alu || (op_i == OpAddi)) begin
          strobes_o.zlow_out = 1'b1;
          strobes_o.gra      = 1'b1;
          strobes_o.r_in     = 1'b1;
        end
      end
      StT6: begin
        if (op_i == OpLd) begin
          strobes_o.md_mux_read = 1'b1;
          strobes_o.ram_read    = 1'b1;
          strobes_o.mdr_in      = 1'b1;
        end else if (op_i == OpSt) begin
          // MDR loads from the bus, so the mux stays on the bus side.
          strobes_o.gra    = 1'b1;
          strobes_o.r_out  = 1'b1;
          strobes_o.mdr_in = 1'b1;
        end
      end
      StT7: begin
        if (op_i == OpLd) begin
          strobes_o.mdr_out = 1'b1;
          strobes_o.gra     = 1'b1;
          strobes_o.r_in    = 1'b1;
        end else if (op_i == OpSt) begin
          strobes_o.ram_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore T-state sequencer: fetch, decode IR[31:27], then per-opcode execute steps.
// Strobes are registered copies of the decode of the next state, so they track the state.
module control_unit
  import cpu_defs::*;
#(
  parameter int unsigned OPW = OpW
) (
  input  logic           clock,
  input  logic           clear,
  control_unit_if.master cu
);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  strobes_t       strobes_q, strobes_d;
  logic           run_q, run_d;

  logic unused_ir;
  assign unused_ir = ^cu.IR[31-OPW:0];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      StReset: state_d = StT0;
      StT0:    state_d = StT1;
      StT1:    state_d = StT2;
      StT2: begin
        op_d = cu.IR[31 -: OPW];
        if (op_d == OpHalt) begin
          state_d = StHalt;
        end else if (last_step(op_d) == StT2) begin
          state_d = cu.stop ? StHalt : StT0;
        end else begin
          state_d = StT3;
        end
      end
      StT3, StT4, StT5, StT6, StT7: begin
        if (state_q == last_step(op_q)) begin
          state_d = cu.stop ? StHalt : StT0;
        end else begin
          unique case (state_q)
            StT3:    state_d = StT4;
            StT4:    state_d = StT5;
            StT5:    state_d = StT6;
            default: state_d = StT7;
          endcase
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StReset;
    endcase
    if (clear) begin
      state_d = StReset;
    end
    run_d = (state_d != StReset) && (state_d != StHalt);
  end

  ctrl_decode u_decode (
    .state_i   (state_d),
    .op_i      (op_d),
    .strobes_o (strobes_d)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= StReset;
      op_q      <= '0;
      strobes_q <= '0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      strobes_q <= strobes_d;
      run_q     <= run_d;
    end
  end

  assign cu.run       = run_q;
  assign cu.PCout     = strobes_q.pc_out;
  assign cu.PCin      = strobes_q.pc_in;
  assign cu.IncPC     = strobes_q.inc_pc;
  assign cu.MARin     = strobes_q.mar_in;
  assign cu.MDRin     = strobes_q.mdr_in;
  assign cu.MDRout    = strobes_q.mdr_out;
  assign cu.MDMuxread = strobes_q.md_mux_read;
  assign cu.RAMread   = strobes_q.ram_read;
  assign cu.RAMwrite  = strobes_q.ram_write;
  assign cu.IRin      = strobes_q.ir_in;
  assign cu.Yin       = strobes_q.y_in;
  assign cu.Zlowin    = strobes_q.zlow_in;
  assign cu.Zlowout   = strobes_q.zlow_out;
  assign cu.CSEout    = strobes_q.cse_out;
  assign cu.Gra       = strobes_q.gra;
  assign cu.Grb       = strobes_q.grb;
  assign cu.Grc       = strobes_q.grc;
  assign cu.Rin       = strobes_q.r_in;
  assign cu.Rout      = strobes_q.r_out;
  assign cu.BAout     = strobes_q.ba_out;
  assign cu.ADD       = strobes_q.alu_add;
  assign cu.SUB       = strobes_q.alu_sub;
  assign cu.AND       = strobes_q.alu_and;
  assign cu.OR        = strobes_q.alu_or;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed literal checks plus randomized run against an
// instruction-level model (mode, step index, instruction class).
module tb_control_unit;

  typedef logic [24:0] vec_t;

  localparam vec_t PCOUT = vec_t'(1) << 0;
  localparam vec_t PCIN  = vec_t'(1) << 1;
  localparam vec_t INCPC = vec_t'(1) << 2;
  localparam vec_t MARIN = vec_t'(1) << 3;
  localparam vec_t MDRIN = vec_t'(1) << 4;
  localparam vec_t MDROUT = vec_t'(1) << 5;
  localparam vec_t MDMUX = vec_t'(1) << 6;
  localparam vec_t RAMRD = vec_t'(1) << 7;
  localparam vec_t RAMWR = vec_t'(1) << 8;
  localparam vec_t IRIN  = vec_t'(1) << 9;
  localparam vec_t YIN   = vec_t'(1) << 10;
  localparam vec_t ZLIN  = vec_t'(1) << 11;
  localparam vec_t ZLOUT = vec_t'(1) << 12;
  localparam vec_t CSE   = vec_t'(1) << 13;
  localparam vec_t GRA   = vec_t'(1) << 14;
  localparam vec_t GRB   = vec_t'(1) << 15;
  localparam vec_t GRC   = vec_t'(1) << 16;
  localparam vec_t RIN   = vec_t'(1) << 17;
  localparam vec_t ROUT  = vec_t'(1) << 18;
  localparam vec_t BAOUT = vec_t'(1) << 19;
  localparam vec_t S_ADD = vec_t'(1) << 20;
  localparam vec_t S_SUB = vec_t'(1) << 21;
  localparam vec_t S_AND = vec_t'(1) << 22;
  localparam vec_t S_OR  = vec_t'(1) << 23;
  localparam vec_t RUN   = vec_t'(1) << 24;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  control_unit_if bus();

  control_unit #(.OPW(5)) dut (
    .clock (clock),
    .clear (clear),
    .cu    (bus)
  );

  vec_t dv;
  assign dv = {bus.run, bus.OR, bus.AND, bus.SUB, bus.ADD, bus.BAout, bus.Rout, bus.Rin,
               bus.Grc, bus.Grb, bus.Gra, bus.CSEout, bus.Zlowout, bus.Zlowin, bus.Yin,
               bus.IRin, bus.RAMwrite, bus.RAMread, bus.MDMuxread, bus.MDRout, bus.MDRin,
               bus.MARin, bus.IncPC, bus.PCin, bus.PCout};

  int vectors = 0;
  int miscompares = 0;

  // Model: mode 0 = reset, 1 = running, 2 = halted; k = step within instruction.
  // Classes: 0 ld, 1 ldi, 2 st, 3 add, 4 sub, 5 and, 6 or, 7 addi, 8 nop, 9 halt.
  int m_mode = 0;
  int m_k = 0;
  int m_cls = 8;

  function automatic int classify(input logic [4:0] op);
    case (op)
      5'b00000: return 0;
      5'b00001: return 1;
      5'b00010: return 2;
      5'b00011: return 3;
      5'b00100: return 4;
      5'b00101: return 5;
      5'b00110: return 6;
      5'b01100: return 7;
      5'b11011: return 9;
      default:  return 8;
    endcase
  endfunction

  function automatic int instr_len(input int cls);
    if (cls == 0 || cls == 2) return 8;
    if (cls == 8) return 3;
    return 6;
  endfunction

  function automatic vec_t alu_sel(input int cls);
    case (cls)
      3: return S_ADD;
      4: return S_SUB;
      5: return S_AND;
      default: return S_OR;
    endcase
  endfunction

  function automatic vec_t expect_vec(input int mode, input int k, input int cls);
    vec_t v;
    bit mem, alu;
    if (mode != 1) return '0;
    mem = (cls <= 2);
    alu = (cls >= 3) && (cls <= 6);
    v = RUN;
    case (k)
      0: v |= PCOUT | MARIN | INCPC | ZLIN;
      1: v |= ZLOUT | PCIN | MDMUX | RAMRD | MDRIN;
      2: v |= MDROUT | IRIN;
      3: v |= mem ? (GRB | BAOUT | YIN) : (GRB | ROUT | YIN);
      4: v |= alu ? (GRC | ROUT | ZLIN | alu_sel(cls)) : (CSE | S_ADD | ZLIN);
      5: v |= (cls == 0 || cls == 2) ? (ZLOUT | MARIN) : (ZLOUT | GRA | RIN);
      6: v |= (cls == 0) ? (MDMUX | RAMRD | MDRIN) : (GRA | ROUT | MDRIN);
      7: v |= (cls == 0) ? (MDROUT | GRA | RIN) : RAMWR;
      default: ;
    endcase
    return v;
  endfunction

  task automatic model_edge(input bit clr, input bit stp, input logic [31:0] ir);
    if (clr) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
      m_k = 0;
    end else if (m_mode == 1) begin
      if (m_k == 2) m_cls = classify(ir[31:27]);
      if (m_k == 2 && m_cls == 9) begin
        m_mode = 2;
      end else if (m_k >= 2 && m_k == instr_len(m_cls) - 1) begin
        if (stp) m_mode = 2;
        else m_k = 0;
      end else begin
        m_k++;
      end
    end
  endtask

  always @(negedge clock) begin
    vec_t e;
    e = expect_vec(m_mode, m_k, m_cls);
    vectors++;
    if (dv !== e) begin
      miscompares++;
      $display("FAIL model t=%0t mode=%0d step=%0d cls=%0d dut=%h expected=%h",
               $time, m_mode, m_k, m_cls, dv, e);
    end
    vectors++;
    if ((bus.RAMread && bus.RAMwrite) || !$onehot0({bus.ADD, bus.SUB, bus.AND, bus.OR})) begin
      miscompares++;
      $display("FAIL invariant t=%0t dut=%h expected at most one ALU select, no RAM rd+wr",
               $time, dv);
    end
  end

  task automatic tick(input bit clr, input bit stp, input logic [31:0] ir);
    clear = clr;
    bus.stop = stp;
    bus.IR = ir;
    @(posedge clock);
    model_edge(clr, stp, ir);
    @(negedge clock);
  endtask

  task automatic lit(input string name, input vec_t exp);
    vectors++;
    if (dv !== exp) begin
      miscompares++;
      $display("FAIL %s: dut=%h expected=%h", name, dv, exp);
    end
  endtask

  logic [31:0] alu_ir [4];
  vec_t        alu_t4 [4];
  logic [4:0]  ops [11];

  initial begin
    logic [31:0] ir;
    logic [31:0] r;
    int pick;
    bit clr, stp;

    alu_ir = '{32'h18918000, 32'h20918000, 32'h28918000, 32'h30918000};
    alu_t4 = '{RUN | GRC | ROUT | ZLIN | S_ADD, RUN | GRC | ROUT | ZLIN | S_SUB,
               RUN | GRC | ROUT | ZLIN | S_AND, RUN | GRC | ROUT | ZLIN | S_OR};
    ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b01100, 5'b11010, 5'b11011, 5'b10101};

    tick(1'b1, 1'b0, 32'h0);
    lit("reset cycle 1", '0);
    tick(1'b1, 1'b0, 32'h0);
    lit("reset cycle 2", '0);

    // ld R2,0x95: every step pinned.
    ir = 32'h01000095;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, ir);
      case (i)
        0: lit("ld T0", RUN | PCOUT | MARIN | INCPC | ZLIN);
        1: lit("ld T1", RUN | ZLOUT | PCIN | MDMUX | RAMRD | MDRIN);
        2: lit("ld T2", RUN | MDROUT | IRIN);
        3: lit("ld T3", RUN | GRB | BAOUT | YIN);
        4: lit("ld T4", RUN | CSE | S_ADD | ZLIN);
        5: lit("ld T5", RUN | ZLOUT | MARIN);
        6: lit("ld T6", RUN | MDMUX | RAMRD | MDRIN);
        default: lit("ld T7", RUN | MDROUT | GRA | RIN);
      endcase
    end

    // ld R0,0x38(R2) back to back.
    ir = 32'h00100038;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, ir);
      if (i == 0) lit("ld2 T0 after T7", RUN | PCOUT | MARIN | INCPC | ZLIN);
      if (i == 3) lit("ld2 T3 BAout", RUN | GRB | BAOUT | YIN);
      if (i == 7) lit("ld2 T7", RUN | MDROUT | GRA | RIN);
    end

    // st 0x87,R1
    ir = 32'h10800087;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, ir);
      if (i == 0) lit("st T0 after ld2", RUN | PCOUT | MARIN | INCPC | ZLIN);
      if (i == 6) lit("st T6", RUN | GRA | ROUT | MDRIN);
      if (i == 7) lit("st T7", RUN | RAMWR);
    end

    // add/sub/and/or, 6 cycles each.
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 6; i++) begin
        tick(1'b0, 1'b0, alu_ir[j]);
        if (i == 0) lit("alu T0 follows prior final", RUN | PCOUT | MARIN | INCPC | ZLIN);
        if (i == 3) lit("alu T3", RUN | GRB | ROUT | YIN);
        if (i == 4) lit("alu T4 select", alu_t4[j]);
      end
    end

    // clear during T5 of ld, then refetch.
    ir = 32'h01000095;
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, ir);
    lit("ld T5 before clear", RUN | ZLOUT | MARIN);
    tick(1'b1, 1'b0, ir);
    lit("clear mid-instruction", '0);
    tick(1'b0, 1'b0, ir);
    lit("refetch T0", RUN | PCOUT | MARIN | INCPC | ZLIN);

    // halt
    ir = 32'hD8000000;
    tick(1'b0, 1'b0, ir);
    tick(1'b0, 1'b0, ir);
    lit("halt T2", RUN | MDROUT | IRIN);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, i[0], ir);
      lit("halted", '0);
    end

    // add: stop mid-instruction ignored, then stop in T5 halts.
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b0, alu_ir[0]);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, alu_ir[0]);
    tick(1'b0, 1'b0, alu_ir[0]);
    lit("stop dropped before final step", RUN | PCOUT | MARIN | INCPC | ZLIN);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, alu_ir[0]);
    lit("add T5", RUN | ZLOUT | GRA | RIN);
    tick(1'b0, 1'b1, alu_ir[0]);
    lit("stop in T5 halts", '0);
    tick(1'b1, 1'b1, alu_ir[0]);
    lit("clear beats stop", '0);

    // Randomized run against the model.
    for (int n = 0; n < 4000; n++) begin
      r = $urandom;
      pick = $urandom_range(0, 11);
      if (pick < 11) r[31:27] = ops[pick];
      clr = (m_mode == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
      stp = ($urandom_range(0, 5) == 0);
      tick(clr, stp, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
